// File: rtl/timer_event_unit.sv
// timer_event_unit: compare-and-event stage behind the 16-bit up-counter.
// Fires a one-cycle match pulse when count arrives at CMP. It also keeps a sticky
// pending/overrun status, a saturating match counter and a small register port.
module timer_event_unit #(
  parameter int CW  = 16,
  parameter int MCW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count,
  input  logic          wr_en,
  input  logic [1:0]    addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic          match,
  output logic          irq
);

  localparam logic [1:0] A_CMP    = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_MCOUNT = 2'd3;

  logic [CW-1:0]  cmp_q;
  logic [CW-1:0]  prev_count_q;
  logic           enable_q;
  logic           irq_en_q;
  logic           pending_q;
  logic           overrun_q;
  logic [MCW-1:0] mcount_q;
  logic           match_q;

  logic           wr_cmp;
  logic           wr_ctrl;
  logic           wr_sts;
  logic           wr_mc;
  logic           hit;
  logic           pending_d;
  logic           overrun_d;
  logic [MCW-1:0] mcount_d;

  // Increment that holds at the all-ones value instead of wrapping.
  function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] v);
    return (&v) ? v : v + MCW'(1);
  endfunction

  assign wr_cmp  = wr_en && (addr == A_CMP);
  assign wr_ctrl = wr_en && (addr == A_CTRL);
  assign wr_sts  = wr_en && (addr == A_STATUS);
  assign wr_mc   = wr_en && (addr == A_MCOUNT);

  // Only an arrival counts: count equals CMP now but did not on the previous cycle.
  // Both sides use register values from before this edge, so a CMP write lands next cycle.
  assign hit = enable_q && (count == cmp_q) && (prev_count_q != cmp_q);

  // Status: a hit (set) beats a same-cycle W1C. Overrun looks at pending before it updates.
  assign pending_d = (pending_q & ~(wr_sts & wdata[0])) | hit;
  assign overrun_d = (overrun_q & ~(wr_sts & wdata[1])) | (hit & pending_q);

  // Match counter: a write clears it, and a hit on the same edge counts as the first match.
  always_comb begin
    mcount_d = mcount_q;
    if (hit) begin
      mcount_d = wr_mc ? MCW'(1) : sat_inc(mcount_q);
    end else if (wr_mc) begin
      mcount_d = '0;
    end
  end

  // State register: the whole block clears asynchronously, because software reads it back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q        <= '0;
      prev_count_q <= '0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      mcount_q     <= '0;
      match_q      <= 1'b0;
    end else begin
      prev_count_q <= count;
      if (wr_cmp) begin
        cmp_q <= CW'(wdata);
      end
      if (wr_ctrl) begin
        enable_q <= wdata[0];
        irq_en_q <= wdata[1];
      end
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      mcount_q  <= mcount_d;
      match_q   <= hit;
    end
  end

  // Read mux: purely combinational, with no side effects on read.
  always_comb begin
    rdata = 16'h0000;
    case (addr)
      A_CMP:    rdata = 16'(cmp_q);
      A_CTRL:   rdata = {14'h0000, irq_en_q, enable_q};
      A_STATUS: rdata = {14'h0000, overrun_q, pending_q};
      A_MCOUNT: rdata = 16'(mcount_q);
      default:  rdata = 16'h0000;
    endcase
  end

  assign match = match_q;
  assign irq   = pending_q & irq_en_q;

endmodule

// File: tb/tb_timer_event_unit.sv
// Directed bench for timer_event_unit: a vector table followed by hand-written corner sequences.
module tb_timer_event_unit;

  logic        clk;
  logic        rst;
  logic [15:0] count;
  logic        wr_en;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        match;
  logic        irq;

  int checks;
  int errors;

  timer_event_unit #(.CW(16), .MCW(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .match (match),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] count;
    logic [1:0]  raddr;
    logic [15:0] exp_rdata;
    logic        exp_match;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [15:0] c);
    count = c;
    step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [15:0] c);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    count = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    count = 16'd0;
    step();
    rst = 1'b0;
  endtask

  // Ramp 0..999, hold 1000 for 50 cycles, then ramp 1001..1200.
  function automatic logic [15:0] ramp_val(input int i);
    if (i < 1000) return 16'(i);
    if (i < 1050) return 16'd1000;
    return 16'(i - 49);
  endfunction

  task automatic run_ramp(output int pulses, output int first_idx);
    pulses = 0;
    first_idx = -1;
    for (int i = 0; i <= 1249; i++) begin
      tick(ramp_val(i));
      if (match) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
  endtask

  initial begin
    logic [15:0] d;
    int pulses;
    int first_idx;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    addr = 2'd0;
    wdata = 16'h0000;
    count = 16'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_match", 32'(match), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk($sformatf("reset_reg%0d", a), 32'(d), 32'd0);
    end
    rst = 1'b0;

    // Vector table: each record is one clock edge followed by a register read
    tbl[0]  = '{1'b1, 2'd0, 16'd5,    16'd0, 2'd0, 16'd5, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd1, 16'hFFFF, 16'd1, 2'd1, 16'd3, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 16'd0,    16'd2, 2'd2, 16'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 16'd0,    16'd5, 2'd2, 16'd1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 16'd0,    16'd5, 2'd3, 16'd1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 16'd0,    16'd6, 2'd2, 16'd1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 16'd0,    16'd5, 2'd2, 16'd3, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 2'd2, 16'd2,    16'd6, 2'd2, 16'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 2'd2, 16'd1,    16'd7, 2'd2, 16'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'd1, 16'd1,    16'd5, 2'd2, 16'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 16'd0,    16'd6, 2'd3, 16'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'd3, 16'h1234, 16'd7, 2'd3, 16'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 2'd1, 16'd0,    16'd5, 2'd1, 16'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 16'd0,    16'd6, 2'd2, 16'd3, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 16'd0,    16'd5, 2'd3, 16'd1, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      wr_en = tbl[i].wr;
      addr  = tbl[i].waddr;
      wdata = tbl[i].wdata;
      count = tbl[i].count;
      step();
      wr_en = 1'b0;
      rd(tbl[i].raddr, d);
      chk($sformatf("vec%0d_rdata", i), 32'(d), 32'(tbl[i].exp_rdata));
      chk($sformatf("vec%0d_match", i), 32'(match), 32'(tbl[i].exp_match));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
    end

    // Basic match with a held value: one pulse, in the cycle after 1000 is sampled
    do_reset();
    wr(2'd0, 16'd1000, 16'd0);
    wr(2'd1, 16'd3, 16'd0);
    run_ramp(pulses, first_idx);
    chk("basic_pulses", 32'(pulses), 32'd1);
    chk("basic_pulse_idx", 32'(first_idx), 32'd1000);
    chk("basic_irq", 32'(irq), 32'd1);
    rd(2'd2, d);
    chk("basic_status", 32'(d), 32'd1);
    rd(2'd3, d);
    chk("basic_mcount", 32'(d), 32'd1);

    // Overrun on a second arrival while pending is still set
    run_ramp(pulses, first_idx);
    chk("ovr_pulses", 32'(pulses), 32'd1);
    rd(2'd2, d);
    chk("ovr_status", 32'(d), 32'd3);
    rd(2'd3, d);
    chk("ovr_mcount", 32'(d), 32'd2);
    wr(2'd2, 16'd2, 16'd1200);
    rd(2'd2, d);
    chk("ovr_clear", 32'(d), 32'd1);

    // W1C and hit on the same edge: the set wins
    wr(2'd2, 16'd3, 16'd1200);
    tick(16'd999);
    wr(2'd2, 16'd1, 16'd1000);
    chk("w1c_hit_match", 32'(match), 32'd1);
    rd(2'd2, d);
    chk("w1c_hit_status", 32'(d), 32'd1);
    tick(16'd999);
    wr(2'd2, 16'd1, 16'd1000);
    rd(2'd2, d);
    chk("w1c_hit_ovr", 32'(d), 32'd3);

    // MCOUNT write and hit on the same edge
    tick(16'd999);
    wr(2'd3, 16'd0, 16'd1000);
    rd(2'd3, d);
    chk("mc_write_hit", 32'(d), 32'd1);

    // CMP write lands on the edge where count reaches the old CMP
    tick(16'd999);
    wr(2'd0, 16'd500, 16'd1000);
    chk("cmp_old_match", 32'(match), 32'd1);
    rd(2'd0, d);
    chk("cmp_new_value", 32'(d), 32'd500);
    tick(16'd499);
    chk("cmp_499_quiet", 32'(match), 32'd0);
    tick(16'd500);
    chk("cmp_new_match", 32'(match), 32'd1);

    // Saturation with irq masked
    do_reset();
    wr(2'd0, 16'd10, 16'd0);
    wr(2'd1, 16'd1, 16'd0);
    repeat (300) begin
      tick(16'd9);
      tick(16'd10);
    end
    rd(2'd3, d);
    chk("sat_mcount", 32'(d), 32'd255);
    chk("mask_irq", 32'(irq), 32'd0);
    rd(2'd2, d);
    chk("mask_pending", 32'(d), 32'd3);

    // Wrap 0xFFFF -> 0 with CMP=0
    wr(2'd0, 16'd0, 16'hFFFE);
    tick(16'hFFFF);
    chk("wrap_pre", 32'(match), 32'd0);
    tick(16'h0000);
    chk("wrap_match", 32'(match), 32'd1);

    // Build pending=1, MCOUNT=5, then reset asynchronously in the middle of a match cycle
    wr(2'd3, 16'd0, 16'd1);
    wr(2'd1, 16'd3, 16'd2);
    repeat (5) begin
      tick(16'hFFFF);
      tick(16'h0000);
    end
    chk("pre_rst_match", 32'(match), 32'd1);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    rd(2'd3, d);
    chk("pre_rst_mcount", 32'(d), 32'd5);
    rst = 1'b1;
    #1;
    chk("async_rst_match", 32'(match), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk($sformatf("async_rst_reg%0d", a), 32'(d), 32'd0);
    end
    step();
    rst = 1'b0;
    wr(2'd1, 16'd1, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick(16'd0);
      chk($sformatf("post_rst_quiet%0d", k), 32'(match), 32'd0);
    end
    tick(16'd1);
    tick(16'd0);
    chk("post_rst_return", 32'(match), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_event_unit.md
# timer_event_unit

Compare-and-event stage that sits directly downstream of the 16-bit up-counter and consumes its `count` output. It detects when the count arrives at a programmable compare value and emits a one-cycle `match` pulse. It keeps a sticky interrupt-pending flag with overrun detection and a saturating match counter. Software programs and reads it through a small word-addressed register port.

## Interface
Parameters:
- `CW`, 16: width of the `count` input and the CMP register.
- `MCW`, 8: width of the saturating match counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `count`  in  CW: counter value from the upstream up-counter, synchronous to `clk`.
- `wr_en`  in  1: register write strobe, one write per asserted cycle.
- `addr`  in  2: register select.
- `wdata`  in  16: write data.
- `rdata`  out  16: read data for `addr`, combinational from registers.
- `match`  out  1: registered one-cycle event pulse.
- `irq`  out  1: `pending & irq_en`, from registers only.

## Operation
Registers:
- addr 0, CMP (RW, CW bits): compare value. Reset 0.
- addr 1, CTRL (RW): bit0 `enable`, bit1 `irq_en`; other bits read 0. Reset 0.
- addr 2, STATUS (W1C): bit0 `pending`, bit1 `overrun`; writing 1 clears the bit, writing 0 has no effect. Reset 0.
- addr 3, MCOUNT (RO value): zero-extended match count. Any write clears it. Reset 0.

Event detection:
- `prev_count` register captures `count` every cycle, regardless of `enable`. Reset 0.
- `hit` = `enable & (count == CMP) & (prev_count != CMP)`. Only arrival at the compare value counts; a held value fires once.
- The comparison uses the CMP value held before the current edge. A CMP write takes effect on the next cycle.
- Setting `enable` while `count` already equals CMP and was equal on the previous cycle does not fire.

On `hit`:
- `match` is set to 1 for exactly one cycle.
- If `pending` is already 1, `overrun` is set, evaluated before `pending` is updated.
- `pending` is set to 1.
- MCOUNT increments and saturates at 2^MCW-1.

Simultaneous events:
- W1C clear and `hit` on the same cycle: set wins. `pending` stays 1. `overrun` is set if `pending` was 1 before the edge.
- MCOUNT write and `hit` on the same cycle: MCOUNT becomes 1.
- Clearing `enable` stops new hits. `pending`, `overrun` and MCOUNT are retained.

Wrap-around:
- A `count` wrap from 0xFFFF to 0 with CMP=0 is an arrival and fires.

Reset:
- Asynchronous `rst` mid-operation forces every register and output to 0 immediately: `match`=0, `irq`=0, `rdata` reflects zeroed registers.
- After reset, `prev_count`=0, so CMP=0 does not fire until `count` leaves 0 and returns.

## Timing
- Latency from edge E: if `count==CMP` is sampled at edge E (with `prev_count!=CMP`), then `match`, `pending` and MCOUNT update at E, visible in the cycle after E.
- `irq` follows `pending` with no extra latency.
- Register writes take effect at the edge where `wr_en` is sampled high.
- `rdata` is combinational from `addr` and registers, with no read side effects.
- `match` is never high on two consecutive cycles unless `count` leaves CMP and returns within one cycle. That cannot happen with a monotonically incrementing source.

## Test plan
- Reset behaviour:
  - Stimulus: assert `rst` mid-run with `pending`=1 and MCOUNT=5.
  - Required response: `irq`, `match`, all registers read 0 immediately; no spurious `match` after release.
- Basic match:
  - Stimulus: CMP=1000, CTRL=3, `count` ramps 0..1200.
  - Required response: exactly one `match` pulse, in the cycle after `count`=1000 is sampled; `irq`=1; STATUS=1; MCOUNT=1.
- Held value:
  - Stimulus: `count` held at 1000 for 50 cycles.
  - Required response: a single `match`.
- Overrun:
  - Stimulus: with `pending` set, `count` ramps past 1000 a second time.
  - Required response: STATUS=3, MCOUNT=2.
  - Follow-up: write STATUS=2; required response: STATUS reads 1.
- Same-cycle collisions:
  - Stimulus: W1C of `pending` on the same edge as a hit. Required response: STATUS bit0 stays 1.
  - Stimulus: MCOUNT write on the same edge as a hit. Required response: MCOUNT=1.
  - Stimulus: CMP written to 500 on the edge where `count`=1000 and `count`=500 arrives later. Required response: match uses old CMP at that edge, then fires at 500.
- Saturation, wrap and masking:
  - Stimulus: MCW=8, 300 arrivals. Required response: MCOUNT=255.
  - Stimulus: CMP=0, `count` wraps 0xFFFF to 0. Required response: `match` fires.
  - Stimulus: `irq_en`=0. Required response: `irq`=0 while `pending`=1.
